// File: rtl/bus_master_ctrl.sv
// Pipelined ping-pong transfer controller for data_path: overlaps address and
// data phases across two register slots and returns one response per request.
module bus_master_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] data_in1,
  output logic [ADDR_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_in3,
  output logic [DATA_W-1:0] data_in4,
  output logic              sel1,
  output logic              sel2,
  output logic              sel3,
  output logic              sel4,
  output logic              mux1,
  output logic              mux2,
  output logic              Aout,
  output logic              Dout,
  output logic              hwrite,
  input  logic [DATA_W-1:0] dout,
  input  logic              rdyout,
  input  logic [1:0]        respout
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic              a_vld_q, a_vld_d;
  logic              a_slot_q, a_slot_d;
  logic              a_write_q, a_write_d;
  logic              d_vld_q, d_vld_d;
  logic              d_slot_q, d_slot_d;
  logic              d_write_q, d_write_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              wptr_q, wptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic d_done_s;
  logic adv_s;
  logic acc_s;

  // Handshake and pipeline advance conditions
  always_comb begin
    d_done_s  = d_vld_q & (rdyout | (wcnt_q == TIMEOUT_C));
    adv_s     = a_vld_q & (~d_vld_q | d_done_s);
    req_ready = ~a_vld_q | adv_s;
    acc_s     = req_valid & req_ready;
  end

  // Next-state computation for both pipeline stages and the response register
  always_comb begin
    a_vld_d     = a_vld_q;
    a_slot_d    = a_slot_q;
    a_write_d   = a_write_q;
    wptr_d      = wptr_q;
    d_vld_d     = d_vld_q;
    d_slot_d    = d_slot_q;
    d_write_d   = d_write_q;
    wcnt_d      = wcnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    // A completing transfer frees its slot, so accept may reuse it in the same cycle
    if (acc_s) begin
      a_vld_d   = 1'b1;
      a_slot_d  = wptr_q;
      a_write_d = req_write;
      wptr_d    = ~wptr_q;
    end else if (adv_s) begin
      a_vld_d = 1'b0;
    end else begin
      a_vld_d = a_vld_q;
    end

    if (adv_s) begin
      d_vld_d   = 1'b1;
      d_slot_d  = a_slot_q;
      d_write_d = a_write_q;
      wcnt_d    = 8'd0;
    end else if (d_done_s) begin
      d_vld_d = 1'b0;
    end else if (d_vld_q) begin
      wcnt_d = wcnt_q + 8'd1;
    end else begin
      wcnt_d = wcnt_q;
    end

    if (d_done_s) begin
      rsp_valid_d = 1'b1;
      if (rdyout) begin
        rsp_err_d   = (respout != 2'b00);
        rsp_rdata_d = d_write_q ? '0 : dout;
      end else begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight transfers silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q     <= 1'b0;
      a_slot_q    <= 1'b0;
      a_write_q   <= 1'b0;
      d_vld_q     <= 1'b0;
      d_slot_q    <= 1'b0;
      d_write_q   <= 1'b0;
      wcnt_q      <= 8'd0;
      wptr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_slot_q    <= a_slot_d;
      a_write_q   <= a_write_d;
      d_vld_q     <= d_vld_d;
      d_slot_q    <= d_slot_d;
      d_write_q   <= d_write_d;
      wcnt_q      <= wcnt_d;
      wptr_q      <= wptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // a_slot only changes on accept, so mux1 naturally holds when the stage is empty
  assign mux1      = a_slot_q;
  assign mux2      = d_slot_q;
  assign Aout      = a_vld_q;
  assign hwrite    = a_vld_q & a_write_q;
  assign Dout      = d_vld_q & d_write_q;

  assign sel1      = acc_s & ~wptr_q;
  assign sel3      = acc_s & ~wptr_q;
  assign sel2      = acc_s & wptr_q;
  assign sel4      = acc_s & wptr_q;

  assign data_in1  = req_addr;
  assign data_in2  = req_addr;
  assign data_in3  = req_wdata;
  assign data_in4  = req_wdata;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: inputs change 1 time unit after a rising
// edge, outputs are sampled on the falling edge of the same cycle.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] data_in1, data_in2;
  logic [31:0] data_in3, data_in4;
  logic        sel1, sel2, sel3, sel4;
  logic        mux1, mux2, Aout, Dout, hwrite;
  logic [31:0] dout = 32'h0;
  logic        rdyout = 1'b1;
  logic [1:0]  respout = 2'b00;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_master_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .mux1(mux1), .mux2(mux2), .Aout(Aout), .Dout(Dout), .hwrite(hwrite),
    .dout(dout), .rdyout(rdyout), .respout(respout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    mid();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_aout", Aout, 0);
    chk("rst_dout_en", Dout, 0);
    chk("rst_mux1", mux1, 0);
    chk("rst_mux2", mux2, 0);
    next();
    rst = 1'b0;

    // Single write, zero wait states
    next();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 32'hDEADBEEF;
    mid();
    chk("w_sel1", sel1, 1);
    chk("w_sel3", sel3, 1);
    chk("w_sel2", sel2, 0);
    chk("w_sel4", sel4, 0);
    chk("w_din1", data_in1, 16'h0010);
    chk("w_din4", data_in4, 32'hDEADBEEF);
    next();
    req_valid = 1'b0;
    mid();
    chk("w_aout", Aout, 1);
    chk("w_hwrite", hwrite, 1);
    chk("w_mux1", mux1, 0);
    next();
    mid();
    chk("w_dout_en", Dout, 1);
    chk("w_mux2", mux2, 0);
    chk("w_aout_off", Aout, 0);
    next();
    mid();
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_err", rsp_err, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    next();
    mid();
    chk("w_rsp_pulse", rsp_valid, 0);

    // Three back-to-back reads
    do_reset();
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
    mid();
    chk("r3_ready0", req_ready, 1);
    chk("r3_slot0", {sel1, sel2}, 2'b10);
    next();
    req_addr = 16'h0200;
    mid();
    chk("r3_ready1", req_ready, 1);
    chk("r3_slot1", {sel1, sel2}, 2'b01);
    chk("r3_hwrite", hwrite, 0);
    next();
    req_addr = 16'h0300; dout = 32'hA;
    mid();
    chk("r3_ready2", req_ready, 1);
    chk("r3_slot2", {sel1, sel2}, 2'b10);
    chk("r3_mux1", mux1, 1);
    next();
    req_valid = 1'b0; dout = 32'hB;
    mid();
    chk("r3_rsp0_v", rsp_valid, 1);
    chk("r3_rsp0_d", rsp_rdata, 32'hA);
    next();
    dout = 32'hC;
    mid();
    chk("r3_rsp1_v", rsp_valid, 1);
    chk("r3_rsp1_d", rsp_rdata, 32'hB);
    next();
    mid();
    chk("r3_rsp2_v", rsp_valid, 1);
    chk("r3_rsp2_d", rsp_rdata, 32'hC);
    chk("r3_rsp2_e", rsp_err, 0);
    next();
    mid();
    chk("r3_idle", rsp_valid, 0);

    // Read with two wait states, followed by a write
    do_reset();
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
    mid();
    chk("ws_ready0", req_ready, 1);
    next();
    req_write = 1'b1; req_addr = 16'h0044; req_wdata = 32'h1234;
    mid();
    chk("ws_ready1", req_ready, 1);
    chk("ws_sel4", sel4, 1);
    next();
    req_valid = 1'b0; rdyout = 1'b0;
    mid();
    chk("ws_stall0", req_ready, 0);
    chk("ws_aout0", Aout, 1);
    chk("ws_mux1_0", mux1, 1);
    chk("ws_dout_en", Dout, 0);
    next();
    mid();
    chk("ws_stall1", req_ready, 0);
    chk("ws_aout1", Aout, 1);
    chk("ws_mux1_1", mux1, 1);
    chk("ws_norsp", rsp_valid, 0);
    next();
    rdyout = 1'b1; dout = 32'h55;
    mid();
    chk("ws_ready_again", req_ready, 1);
    next();
    mid();
    chk("ws_rd_v", rsp_valid, 1);
    chk("ws_rd_d", rsp_rdata, 32'h55);
    chk("ws_wr_phase", Dout, 1);
    chk("ws_mux2", mux2, 1);
    next();
    mid();
    chk("ws_wr_v", rsp_valid, 1);
    chk("ws_wr_d", rsp_rdata, 0);
    chk("ws_wr_e", rsp_err, 0);

    // Error response
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0080;
    next();
    req_valid = 1'b0;
    next();
    respout = 2'b01; dout = 32'h99;
    next();
    respout = 2'b00;
    mid();
    chk("err_v", rsp_valid, 1);
    chk("err_e", rsp_err, 1);
    chk("err_d", rsp_rdata, 32'h99);
    next();
    mid();
    chk("err_pulse", rsp_valid, 0);

    // Timeout with a second read queued behind it
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0500;
    mid();
    chk("to_ready0", req_ready, 1);
    next();
    req_addr = 16'h0600; rdyout = 1'b0; dout = 32'hBAD;
    mid();
    chk("to_ready1", req_ready, 1);
    next();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mid();
      chk("to_wait_rsp", rsp_valid, 0);
      chk("to_wait_ready", req_ready, 0);
      next();
    end
    mid();
    chk("to_done_ready", req_ready, 1);
    chk("to_done_norsp", rsp_valid, 0);
    next();
    rdyout = 1'b1; dout = 32'h77;
    mid();
    chk("to_rsp_v", rsp_valid, 1);
    chk("to_rsp_e", rsp_err, 1);
    chk("to_rsp_d", rsp_rdata, 0);
    next();
    mid();
    chk("to_next_v", rsp_valid, 1);
    chk("to_next_e", rsp_err, 0);
    chk("to_next_d", rsp_rdata, 32'h77);

    // Asynchronous reset with two transfers in flight
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0700;
    mid();
    chk("ar_sel2", sel2, 1);
    next();
    req_write = 1'b1; req_addr = 16'h0704;
    next();
    req_valid = 1'b0; rdyout = 1'b0;
    mid();
    chk("ar_pre_mux2", mux2, 1);
    chk("ar_pre_aout", Aout, 1);
    next();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_aout", Aout, 0);
    chk("ar_dout_en", Dout, 0);
    chk("ar_mux2", mux2, 0);
    chk("ar_ready", req_ready, 1);
    chk("ar_rsp_v", rsp_valid, 0);
    rdyout = 1'b1;
    next();
    next();
    rst = 1'b0;
    mid();
    chk("ar_post0", rsp_valid, 0);
    next();
    mid();
    chk("ar_post1", rsp_valid, 0);
    next();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0800;
    mid();
    chk("ar_first_slot", {sel1, sel2}, 2'b10);
    next();
    req_valid = 1'b0;
    mid();
    chk("ar_first_mux1", mux1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
